// File: rtl/lag_pkg.sv
// Shared constants, FSM state type and result-limiting helper for lag_remover.
// Optional feature macro: LAG_REMOVER_SAT_EN. When it is defined, results
// saturate to the signed 32-bit range. When it is not defined, results wrap.
package lag_pkg;

  localparam int SAMPLE_W = 32;
  localparam int COEF_W   = 16;
  localparam int FRAC_W   = 14;
  localparam int ACC_W    = 50;
  localparam int PROD_W   = SAMPLE_W + COEF_W;
  localparam int RES_W    = ACC_W - FRAC_W;

  localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(1) << (FRAC_W - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MAC1 = 3'd1,
    MAC2 = 3'd2,
    MAC3 = 3'd3,
    OUT  = 3'd4
  } state_e;

  // Converts the Q.14 accumulator to a 32-bit sample, rounding half up.
  function automatic logic signed [SAMPLE_W-1:0] round_limit(
    input logic signed [ACC_W-1:0] acc
  );
    logic signed [ACC_W-1:0] biased;
    logic signed [RES_W-1:0] shifted;
    logic signed [SAMPLE_W-1:0] res;
    biased  = acc + ROUND_BIAS;
    shifted = RES_W'(biased >>> FRAC_W);
`ifdef LAG_REMOVER_SAT_EN
    // The value fits when all bits above the 32-bit sign bit match it.
    if ((&shifted[RES_W-1:SAMPLE_W-1]) || !(|shifted[RES_W-1:SAMPLE_W-1])) begin
      res = SAMPLE_W'(shifted);
    end else if (shifted[RES_W-1]) begin
      res = {1'b1, {(SAMPLE_W-1){1'b0}}};
    end else begin
      res = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
`else
    res = SAMPLE_W'(shifted);
`endif
    return res;
  endfunction

endpackage

// File: rtl/lag_mac.sv
// Registered multiply-subtract: acc <= acc - sample*coef, or a fresh load.
module lag_mac
  import lag_pkg::*;
(
  input  logic                       clk_samplying,
  input  logic                       rst,
  input  logic                       load_i,
  input  logic signed [ACC_W-1:0]    load_val_i,
  input  logic                       sub_en_i,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic signed [COEF_W-1:0]   coef_i,
  output logic signed [ACC_W-1:0]    acc_o
);

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [PROD_W-1:0] prod;

  // Next accumulator value: load wins over subtract, otherwise hold.
  always_comb begin
    // NOTE: every variable in a combinational block gets a default first so no latch is inferred.
    prod  = sample_i * coef_i;
    acc_d = acc_q;
    if (load_i) begin
      acc_d = load_val_i;
    end else if (sub_en_i) begin
      acc_d = acc_q - ACC_W'(prod);
    end
  end

  // Accumulator register with synchronous clear.
  always_ff @(posedge clk_samplying) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/lag_remover.sv
// lag_remover: inverts a 4-tap lag filter,
//   x[n] = y[n] - c1*x[n-1] - c2*x[n-2] - c3*x[n-3]
// This is one sample per five cycles through IDLE -> MAC1 -> MAC2 -> MAC3 -> OUT.
// Optional feature macro: LAG_REMOVER_SAT_EN. Define it to saturate results
// instead of wrapping them.
module lag_remover
  import lag_pkg::*;
(
  input  logic                       clk_samplying,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [SAMPLE_W-1:0] signal_lag,
  input  logic                       coef_load,
  input  logic signed [COEF_W-1:0]   coef_1,
  input  logic signed [COEF_W-1:0]   coef_2,
  input  logic signed [COEF_W-1:0]   coef_3,
  output logic signed [SAMPLE_W-1:0] signal_rec,
  output logic                       out_valid
);

  state_e state_q, state_d;

  logic signed [COEF_W-1:0]   coef1_q, coef2_q, coef3_q;
  logic signed [SAMPLE_W-1:0] x1_q, x2_q, x3_q;
  logic signed [SAMPLE_W-1:0] rec_q;
  logic                       out_valid_q;

  logic                       accept;
  logic                       mac_sub;
  logic signed [SAMPLE_W-1:0] mac_sample;
  logic signed [COEF_W-1:0]   mac_coef;
  logic signed [ACC_W-1:0]    load_val;
  logic signed [ACC_W-1:0]    acc;
  logic signed [SAMPLE_W-1:0] result;

  assign accept   = in_valid & in_ready;
  assign load_val = {{(ACC_W-SAMPLE_W-FRAC_W){signal_lag[SAMPLE_W-1]}},
                     signal_lag, {FRAC_W{1'b0}}};
  assign result   = round_limit(acc);

  // FSM state register.
  always_ff @(posedge clk_samplying) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: only IDLE waits for input, the rest advance every cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = MAC1;
      MAC1:    state_d = MAC2;
      MAC2:    state_d = MAC3;
      MAC3:    state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: handshake and MAC operand selection per tap.
  always_comb begin
    in_ready   = 1'b0;
    mac_sub    = 1'b0;
    mac_sample = '0;
    mac_coef   = '0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      MAC1: begin mac_sub = 1'b1; mac_sample = x1_q; mac_coef = coef1_q; end
      MAC2: begin mac_sub = 1'b1; mac_sample = x2_q; mac_coef = coef2_q; end
      MAC3: begin mac_sub = 1'b1; mac_sample = x3_q; mac_coef = coef3_q; end
      default: ;
    endcase
  end

  lag_mac u_mac (
    .clk_samplying (clk_samplying),
    .rst           (rst),
    .load_i        (accept),
    .load_val_i    (load_val),
    .sub_en_i      (mac_sub),
    .sample_i      (mac_sample),
    .coef_i        (mac_coef),
    .acc_o         (acc)
  );

  // Coefficients change only between samples, so a sample in flight always uses one consistent set.
  always_ff @(posedge clk_samplying) begin
    if (rst) begin
      coef1_q <= '0;
      coef2_q <= '0;
      coef3_q <= '0;
    end else if (coef_load && state_q == IDLE) begin
      coef1_q <= coef_1;
      coef2_q <= coef_2;
      coef3_q <= coef_3;
    end
  end

  // Publish the result and shift the history on OUT.
  always_ff @(posedge clk_samplying) begin
    if (rst) begin
      x1_q        <= '0;
      x2_q        <= '0;
      x3_q        <= '0;
      rec_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state_q == OUT);
      if (state_q == OUT) begin
        rec_q <= result;
        x3_q  <= x2_q;
        x2_q  <= x1_q;
        x1_q  <= result;
      end
    end
  end

  assign signal_rec = rec_q;
  assign out_valid  = out_valid_q;

endmodule

// File: doc/lag_remover.md
LAG_REMOVER -- requirements
Module: lag_remover

Interface
REQ-001 SHALL have port clk_samplying, input, 1, sole clock; all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1, lagged sample present on signal_lag.
REQ-004 SHALL have port in_ready, output, 1, block can accept a sample (high only in IDLE).
REQ-005 SHALL have port signal_lag, input, 32, signed lagged sample y[n].
REQ-006 SHALL have port coef_load, input, 1, latch coef_1..coef_3 this cycle.
REQ-007 SHALL have ports coef_1, coef_2, coef_3, input, 16 each, signed Q2.14 normalized weights c_k = p_k/p_0.
REQ-008 SHALL have port signal_rec, output, 32, signed recovered sample x[n].
REQ-009 SHALL have port out_valid, output, 1, one-cycle pulse marking signal_rec valid.

Function
REQ-010 SHALL compute x[n] = y[n] - c1*x[n-1] - c2*x[n-2] - c3*x[n-3], inverting the 4-tap lag filter.
REQ-011 SHALL use FSM states IDLE, MAC1, MAC2, MAC3, OUT: IDLE->MAC1 on in_valid&in_ready; MAC1->MAC2->MAC3->OUT unconditionally; OUT->IDLE.
REQ-012 SHALL initialize the 50-bit signed accumulator to y<<14 on accept; MACk subtracts c_k*x[n-k] (48-bit product, sign-extended).
REQ-013 SHALL form the result as (acc + 2^13) >>> 14 (round half up), then limit to 32 bits per REQ-024/025.
REQ-014 SHALL assert out_valid with signal_rec updated exactly 4 cycles after the accepting edge (accept at T, pulse at T+4).
REQ-015 SHALL hold signal_rec at its last value between pulses.
REQ-016 SHALL shift history on OUT: x3<=x2, x2<=x1, x1<=final 32-bit result.
REQ-017 SHALL ignore in_valid when in_ready is low; no sample is queued.
REQ-018 SHALL latch coefficients only when coef_load is high in IDLE; when coef_load is high in other states, SHALL ignore it.
REQ-019 SHALL, when coef_load and an accepted in_valid occur in the same IDLE cycle, latch the new coefficients and use them for that sample.

Reset
REQ-020 SHALL, on rst, set FSM to IDLE, in_ready=1, out_valid=0, signal_rec=0, accumulator=0, x1=x2=x3=0, coef registers=0.
REQ-021 SHALL, on rst mid-operation, abort the sample with no out_valid pulse and clear history; rst has priority over all other inputs.

Configuration
REQ-022 SHALL compile the saturation feature with macro LAG_REMOVER_SAT_EN.
REQ-023 SHALL expose no parameters; widths are fixed constants.
REQ-024 SHALL, with LAG_REMOVER_SAT_EN defined, clamp the result to [0x80000000, 0x7FFFFFFF].
REQ-025 SHALL, without LAG_REMOVER_SAT_EN, truncate the result to its low 32 bits (two's-complement wrap).

Structure
REQ-026 SHALL take SAMPLE_W=32, COEF_W=16, FRAC_W=14, ACC_W=50 and the FSM state enum from shared package lag_pkg.
REQ-027 SHALL use one sub-module, lag_mac: a registered multiply-subtract of a 32x16 signed product from the 50-bit accumulator.

Verification
REQ-028 SHALL cover: coefs all 0, y=12345 accepted at T -> out_valid at T+4, signal_rec=12345.
REQ-029 SHALL cover: c1=0x2000 (0.5), y=1000,0,0 -> x=1000,-500,250.
REQ-030 SHALL cover: c1=0x8000 (-2.0), y=0x7FFFFFFF twice -> second x=0x7FFFFFFF with LAG_REMOVER_SAT_EN, 0x7FFFFFFD without.
REQ-031 SHALL cover: in_valid held high continuously -> one sample accepted per 5 cycles; in_ready low in MAC1..OUT.
REQ-032 SHALL cover: rst in MAC2 -> no out_valid, in_ready=1 next cycle, a following y=7 with c=0 -> x=7.
REQ-033 SHALL cover: coef_load with c1=0x2000 during MAC1 -> ignored; the next sample still uses the old coefficients.
